uart_alu_ctrl: RTL and testbench

Parametrised successor to the single-byte UART-to-ALU command bridge. Parses framed commands from the UART RX byte stream and assembles multi-byte operands A and B (little-endian). On an OP frame it issues a one-cycle ALU strobe, captures the ALU result, and serialises it byte-by-byte to UART TX using the tx_done handshake. Adds inter-byte timeout, header validation and error reporting.

---
 rtl/uart_alu_pkg.sv | 26 ++
 rtl/uart_tx_serializer.sv | 75 +++++++
 rtl/uart_alu_ctrl.sv | 177 +++++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared constants and types for the UART-to-ALU command bridge.
package uart_alu_pkg;

    localparam logic [7:0] HDR_A  = 8'h08;
    localparam logic [7:0] HDR_B  = 8'h10;
    localparam logic [7:0] HDR_OP = 8'h20;

    localparam logic [1:0] ERR_HDR = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;
    localparam logic [1:0] ERR_OVR = 2'b11;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_PAYLOAD = 5'b00010,
        ST_EXEC    = 5'b00100,
        ST_SEND    = 5'b01000,
        ST_WAIT_TX = 5'b10000
    } state_t;

    typedef enum logic [1:0] {
        FR_A,
        FR_B,
        FR_OP
    } frame_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// Sends an NB_DATA-wide result LSB byte first over a tx_start/tx_done byte handshake.
module uart_tx_serializer
    import uart_alu_pkg::*;
#(
    parameter int unsigned NB_BYTE = 8,
    parameter int unsigned NB_DATA = 16
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_data,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
    localparam int unsigned IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] res_q, res_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        idx_d      = idx_q;
        o_tx_start = 1'b0;
        o_done     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    res_d   = i_data;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                o_tx_start = 1'b1;
                state_d    = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // Comparing against N_BYTES-1 before the increment keeps idx within its width
                if (i_tx_done) begin
                    if (idx_q == IDX_W'(N_BYTES - 1)) begin
                        o_done  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_data = res_q[idx_q*NB_BYTE +: NB_BYTE];

endmodule

// File: rtl/uart_alu_ctrl.sv
// Framed UART command parser: loads operands A/B and opcode, strobes the ALU and
// returns the result over UART TX, with header, timeout and overrun error reporting.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int unsigned NB_BYTE     = 8,
    parameter int unsigned NB_DATA     = 16,
    parameter int unsigned NB_OP       = 6,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_BYTE-1:0] i_rx,
    input  logic               i_rxDone,
    input  logic               i_txDone,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_data,
    output logic [NB_OP-1:0]   o_operation,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic               o_valid,
    input  logic [NB_DATA-1:0] i_result,
    output logic               o_err,
    output logic [1:0]         o_err_code
);

    localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
    localparam int unsigned CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);

    state_t             state_q, state_d;
    frame_t             frame_q, frame_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [NB_DATA-1:0] shadow_q, shadow_d;
    logic [NB_DATA-1:0] dato_a_q, dato_a_d;
    logic [NB_DATA-1:0] dato_b_q, dato_b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;

    logic [NB_DATA-1:0] shadow_next;
    logic               last_byte;
    logic               ser_busy;
    logic               ser_done;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            frame_q    <= FR_A;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            shadow_q   <= '0;
            dato_a_q   <= '0;
            dato_b_q   <= '0;
            op_q       <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            shadow_q   <= shadow_d;
            dato_a_q   <= dato_a_d;
            dato_b_q   <= dato_b_d;
            op_q       <= op_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        shadow_next = shadow_q;
        for (int unsigned i = 0; i < N_BYTES; i++) begin
            if (byte_cnt_q == CNT_W'(i)) begin
                shadow_next[i*NB_BYTE +: NB_BYTE] = i_rx;
            end
        end
    end

    assign last_byte = (byte_cnt_q == CNT_W'(N_BYTES - 1));

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        byte_cnt_d = byte_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        shadow_d   = shadow_q;
        dato_a_d   = dato_a_q;
        dato_b_d   = dato_b_q;
        op_d       = op_q;
        err_d      = 1'b0;
        err_code_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_rxDone) begin
                    if (i_rx == NB_BYTE'(HDR_A) || i_rx == NB_BYTE'(HDR_B) ||
                        i_rx == NB_BYTE'(HDR_OP)) begin
                        if (i_rx == NB_BYTE'(HDR_A))      frame_d = FR_A;
                        else if (i_rx == NB_BYTE'(HDR_B)) frame_d = FR_B;
                        else                              frame_d = FR_OP;
                        byte_cnt_d = '0;
                        tmo_cnt_d  = '0;
                        shadow_d   = '0;
                        state_d    = ST_PAYLOAD;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_HDR;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (i_rxDone) begin
                    tmo_cnt_d = '0;
                    if (frame_q == FR_OP) begin
                        op_d    = i_rx[NB_OP-1:0];
                        state_d = ST_EXEC;
                    end else begin
                        shadow_d   = shadow_next;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        // Operands only change once the whole frame has arrived
                        if (last_byte) begin
                            if (frame_q == FR_A) dato_a_d = shadow_next;
                            else                 dato_b_d = shadow_next;
                            shadow_d = '0;
                            state_d  = ST_IDLE;
                        end
                    end
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TMO;
                    tmo_cnt_d  = '0;
                    shadow_d   = '0;
                    state_d    = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_EXEC:    state_d = ST_SEND;
            ST_SEND:    state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (ser_done)      state_d = ST_IDLE;
                else if (i_txDone) state_d = ST_SEND;
            end
            default:    state_d = ST_IDLE;
        endcase

        if (i_rxDone && (state_q == ST_EXEC || ser_busy)) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVR;
        end
    end

    assign o_valid     = (state_q == ST_EXEC);
    assign o_operation = op_q;
    assign o_datoA     = dato_a_q;
    assign o_datoB     = dato_b_q;
    assign o_err       = err_q;
    assign o_err_code  = err_code_q;

    uart_tx_serializer #(
        .NB_BYTE (NB_BYTE),
        .NB_DATA (NB_DATA)
    ) u_ser (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_start    (o_valid),
        .i_data     (i_result),
        .i_tx_done  (i_txDone),
        .o_tx_start (o_tx_start),
        .o_data     (o_data),
        .o_busy     (ser_busy),
        .o_done     (ser_done)
    );

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: table of A/B/OP transactions plus
// hand-written timeout, bad-header, overrun and asynchronous-reset sequences.
module tb_uart_alu_ctrl;

    localparam int unsigned TMO = 50;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_rx = '0;
    logic        i_rxDone = 1'b0;
    logic        i_txDone = 1'b0;
    logic        o_tx_start;
    logic [7:0]  o_data;
    logic [5:0]  o_operation;
    logic [15:0] o_datoA, o_datoB;
    logic        o_valid;
    logic [15:0] i_result;
    logic        o_err;
    logic [1:0]  o_err_code;

    int vectors = 0, miscompares = 0;
    int cyc = 0, last_rx_cyc = 0, txdone_cyc = 0, err_cyc = -1, tx_idx = 0;
    int tx_lat = 2, rst_epoch = 0, resp_epoch = 0, n = 0;
    logic [7:0]  tx_held;
    logic [15:0] exp_a = '0, exp_b = '0;

    typedef struct packed { logic [5:0] op; logic [15:0] a; logic [15:0] b; } exec_t;
    exec_t      exp_exec[$];
    exec_t      got_exec;
    logic [7:0] exp_tx[$];
    logic [1:0] exp_err[$];

    typedef struct { logic [15:0] a; logic [15:0] b; logic [5:0] op; } vec_t;
    vec_t tbl[5];

    uart_alu_ctrl #(
        .NB_BYTE     (8),
        .NB_DATA     (16),
        .NB_OP       (6),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_rx        (i_rx),
        .i_rxDone    (i_rxDone),
        .i_txDone    (i_txDone),
        .o_tx_start  (o_tx_start),
        .o_data      (o_data),
        .o_operation (o_operation),
        .o_datoA     (o_datoA),
        .o_datoB     (o_datoB),
        .o_valid     (o_valid),
        .i_result    (i_result),
        .o_err       (o_err),
        .o_err_code  (o_err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] alu_ref(input logic [5:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign i_result = alu_ref(o_operation, o_datoA, o_datoB);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard whenever the DUT produces an event
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_valid) begin
                if (exp_exec.size() == 0) begin
                    check("unexpected o_valid", o_valid, 1'b0);
                end else begin
                    got_exec = exp_exec.pop_front();
                    check("exec opcode", o_operation, got_exec.op);
                    check("exec datoA", o_datoA, got_exec.a);
                    check("exec datoB", o_datoB, got_exec.b);
                    check("o_valid latency", cyc, last_rx_cyc + 1);
                end
                tx_idx = 0;
            end
            if (o_tx_start) begin
                if (exp_tx.size() == 0) check("unexpected o_tx_start", o_tx_start, 1'b0);
                else                    check("tx byte", o_data, exp_tx.pop_front());
                if (tx_idx == 0) check("first tx_start latency", cyc, last_rx_cyc + 2);
                else             check("tx_start after txDone", cyc, txdone_cyc + 1);
                tx_idx++;
            end
            if (o_err) begin
                err_cyc = cyc;
                if (exp_err.size() == 0) check("unexpected o_err", o_err, 1'b0);
                else                     check("err code", o_err_code, exp_err.pop_front());
            end
        end
    end

    // UART TX model: acknowledges each byte tx_lat cycles after its start
    initial begin
        forever begin
            @(negedge clk);
            i_txDone = 1'b0;
            if (!i_rst && o_tx_start) begin
                resp_epoch = rst_epoch;
                tx_held    = o_data;
                repeat (tx_lat) @(negedge clk);
                if (resp_epoch == rst_epoch && !i_rst) begin
                    check("o_data hold", o_data, tx_held);
                    i_txDone   = 1'b1;
                    txdone_cyc = cyc;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx        = b;
        i_rxDone    = 1'b1;
        last_rx_cyc = cyc;
        @(negedge clk);
        i_rxDone = 1'b0;
    endtask

    task automatic send_operand(input logic [7:0] hdr, input logic [15:0] v);
        send_byte(hdr);
        send_byte(v[7:0]);
        send_byte(v[15:8]);
    endtask

    task automatic send_op(input logic [5:0] op);
        logic [15:0] r;
        r = alu_ref(op, exp_a, exp_b);
        exp_exec.push_back(exec_t'{op: op, a: exp_a, b: exp_b});
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
        send_byte(8'h20);
        send_byte({2'b00, op});
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_tx.size() != 0 || exp_exec.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("tx queue drained", exp_tx.size(), 0);
        repeat (8) @(negedge clk);
        check("err queue drained", exp_err.size(), 0);
    endtask

    task automatic wait_tx_start();
        int k = 0;
        while (!o_tx_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("tx_start seen", o_tx_start, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{a: 16'hBEEF, b: 16'h0101, op: 6'h20};
        tbl[1] = '{a: 16'h0100, b: 16'h0001, op: 6'h22};
        tbl[2] = '{a: 16'hF0F0, b: 16'h3CC3, op: 6'h24};
        tbl[3] = '{a: 16'hFFFF, b: 16'h0001, op: 6'h20};
        tbl[4] = '{a: 16'h5A5A, b: 16'h00FF, op: 6'h3F};

        repeat (3) @(negedge clk);
        check("reset outputs", {o_tx_start, o_data, o_operation, o_datoA, o_datoB,
                                o_valid, o_err, o_err_code}, 64'd0);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Operand frames alone never strobe the ALU
        send_operand(8'h08, 16'h1234);
        exp_a = 16'h1234;
        check("datoA after A frame", o_datoA, 16'h1234);
        send_operand(8'h10, 16'h0002);
        exp_b = 16'h0002;
        check("datoA after B frame", o_datoA, 16'h1234);
        check("datoB after B frame", o_datoB, 16'h0002);

        tx_lat = 1;
        send_op(6'h20);
        wait_drain();

        // Timeout discards a partial A frame
        exp_err.push_back(2'b10);
        send_byte(8'h08);
        send_byte(8'hAA);
        check("datoA not partially updated", o_datoA, 16'h1234);
        err_cyc = -1;
        n = 0;
        while (err_cyc < 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout error cycle", err_cyc, last_rx_cyc + 1 + TMO);
        check("datoA after timeout", o_datoA, 16'h1234);
        send_operand(8'h08, 16'h0001);
        exp_a = 16'h0001;
        check("datoA after timeout recovery", o_datoA, 16'h0001);

        // A byte arriving exactly as the counter expires is accepted
        send_byte(8'h08);
        send_byte(8'h11);
        repeat (TMO - 2) @(negedge clk);
        send_byte(8'h22);
        exp_a = 16'h2211;
        check("datoA byte at timeout boundary", o_datoA, 16'h2211);

        exp_err.push_back(2'b01);
        send_byte(8'h55);
        repeat (2) @(negedge clk);
        send_operand(8'h10, 16'hA5C3);
        exp_b = 16'hA5C3;
        check("datoB after bad header", o_datoB, 16'hA5C3);
        check("bad header error seen", exp_err.size(), 0);

        foreach (tbl[i]) begin
            tx_lat = $urandom_range(1, 4);
            send_operand(8'h08, tbl[i].a);
            exp_a = tbl[i].a;
            send_operand(8'h10, tbl[i].b);
            exp_b = tbl[i].b;
            check("table datoA", o_datoA, tbl[i].a);
            check("table datoB", o_datoB, tbl[i].b);
            send_op(tbl[i].op);
            wait_drain();
        end

        // Overrun during WAIT_TX: byte dropped, result bytes unaffected
        tx_lat = 4;
        send_op(6'h22);
        wait_tx_start();
        exp_err.push_back(2'b11);
        send_byte(8'h99);
        wait_drain();
        check("datoA after overrun", o_datoA, exp_a);
        check("datoB after overrun", o_datoB, exp_b);

        // Asynchronous reset mid-transmission
        send_op(6'h20);
        wait_tx_start();
        #2;
        i_rst = 1'b1;
        rst_epoch++;
        #1;
        check("async reset outputs", {o_tx_start, o_data, o_operation, o_datoA, o_datoB,
                                      o_valid, o_err, o_err_code}, 64'd0);
        exp_tx.delete();
        exp_exec.delete();
        exp_a = '0;
        exp_b = '0;
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        repeat (6) @(negedge clk);

        tx_lat = 2;
        send_operand(8'h08, 16'h0F0F);
        exp_a = 16'h0F0F;
        send_operand(8'h10, 16'h00F1);
        exp_b = 16'h00F1;
        check("datoA after reset", o_datoA, 16'h0F0F);
        check("datoB after reset", o_datoB, 16'h00F1);
        send_op(6'h20);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
